register_file: RTL and testbench

// 32 x 32-bit MIPS general-purpose register file. It is the consumer of the

---
 rtl/register_file.sv | 75 +++++++
 tb/tb_register_file.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit MIPS general-purpose register file with two combinational operand
// read ports, optional write-to-read bypass, a registered debug port and a write counter.
module register_file #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int WRITE_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_reg,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DATA_W-1:0] dbg_data_reg;
  logic [15:0]       wr_count_reg;
  logic              wr_en;

  // r0 is never a legal destination, so it keeps its reset value of zero.
  assign wr_en = RegWrite_in && (write_reg != '0);

  // Every entry needs an asynchronous clear, so the array is built from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_reg <= '0;
      dbg_data_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
      dbg_data_reg <= regs_reg[dbg_reg];
    end
  end

  logic [ADDR_W-1:0] rd_idx  [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_idx[0] = read_reg1;
  assign rd_idx[1] = read_reg2;

  // Each read port resolves independently; wr_en already excludes r0 from the bypass.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rd_port
      assign rd_data[gi] = rst ? '0 :
                           ((WRITE_FIRST != 0) && wr_en && (write_reg == rd_idx[gi])) ? write_data :
                           regs_reg[rd_idx[gi]];
    end
  endgenerate

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];
  assign dbg_data   = dbg_data_reg;
  assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, randomized run
// against an array model, async reset mid-write and write-counter wrap.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in;
  logic [4:0]  write_reg, read_reg1, read_reg2, dbg_reg;
  logic [31:0] write_data;
  logic [31:0] rd1_wf, rd2_wf, dbg_wf, rd1_rf, rd2_rf, dbg_rf;
  logic [15:0] cnt_wf, cnt_rf;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_regs [32];
  logic [15:0] model_cnt;

  register_file #(.DATA_W(32), .ADDR_W(5), .WRITE_FIRST(1)) dut_wf (
    .clk(clk), .rst(rst), .RegWrite_in(RegWrite_in), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_wf), .read_data2(rd2_wf), .dbg_reg(dbg_reg),
    .dbg_data(dbg_wf), .wr_count(cnt_wf)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .WRITE_FIRST(0)) dut_rf (
    .clk(clk), .rst(rst), .RegWrite_in(RegWrite_in), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_rf), .read_data2(rd2_rf), .dbg_reg(dbg_reg),
    .dbg_data(dbg_rf), .wr_count(cnt_rf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1, r2, dbg;
    logic [31:0] e1_wf, e2_wf, e1_rf, e2_rf, e_dbg;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r, input bit bypass);
    if (r == 5'd0) return 32'h0;
    if (bypass && RegWrite_in && write_reg != 5'd0 && write_reg == r) return write_data;
    return model_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 16'h0;
  endtask

  // Applies the write presented on the inputs to the model (what the next edge commits).
  task automatic model_commit();
    if (RegWrite_in && write_reg != 5'd0) begin
      model_regs[write_reg] = write_data;
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    @(negedge clk);
    RegWrite_in = we;
    write_reg   = wreg;
    write_data  = wdata;
    read_reg1   = r1;
    read_reg2   = r2;
    dbg_reg     = dbg;
  endtask

  initial begin
    logic [31:0] exp_dbg;

    rst = 1'b1;
    RegWrite_in = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd1; read_reg2 = 5'd2; dbg_reg = 5'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd1", rd1_wf, 32'h0);
    check("reset_cnt", {16'h0, cnt_wf}, 32'h0);
    check("reset_dbg", dbg_wf, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, starting from the cleared array.
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
    tbl[2] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 32'h0, 16'd2};
    tbl[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 5'd0, 32'h0, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 16'd2};
    tbl[4] = '{1'b0, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd2};
    tbl[5] = '{1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd5, 5'd7, 32'hCAFEF00D, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 16'd3};

    for (int v = 0; v < 6; v++) begin
      drive(tbl[v].we, tbl[v].wreg, tbl[v].wdata, tbl[v].r1, tbl[v].r2, tbl[v].dbg);
      #1;
      check($sformatf("tbl%0d_rd1_wf", v), rd1_wf, tbl[v].e1_wf);
      check($sformatf("tbl%0d_rd2_wf", v), rd2_wf, tbl[v].e2_wf);
      check($sformatf("tbl%0d_rd1_rf", v), rd1_rf, tbl[v].e1_rf);
      check($sformatf("tbl%0d_rd2_rf", v), rd2_rf, tbl[v].e2_rf);
      model_commit();
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_dbg", v), dbg_wf, tbl[v].e_dbg);
      check($sformatf("tbl%0d_cnt", v), {16'h0, cnt_wf}, {16'h0, tbl[v].e_cnt});
      $display("tbl %0d: we=%0b wreg=%0d wdata=%h r1=%0d->%h r2=%0d->%h cnt=%0d",
               v, tbl[v].we, tbl[v].wreg, tbl[v].wdata, tbl[v].r1, rd1_wf, tbl[v].r2, rd2_wf, cnt_wf);
    end

    // Randomized run against the array model.
    for (int t = 0; t < 300; t++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) read_reg2 = write_reg;
      #1;
      check("rnd_rd1_wf", rd1_wf, model_read(read_reg1, 1'b1));
      check("rnd_rd2_wf", rd2_wf, model_read(read_reg2, 1'b1));
      check("rnd_rd1_rf", rd1_rf, model_read(read_reg1, 1'b0));
      check("rnd_rd2_rf", rd2_rf, model_read(read_reg2, 1'b0));
      exp_dbg = model_read(dbg_reg, 1'b0);
      model_commit();
      @(posedge clk);
      #1;
      check("rnd_dbg_wf", dbg_wf, exp_dbg);
      check("rnd_dbg_rf", dbg_rf, exp_dbg);
      check("rnd_cnt_wf", {16'h0, cnt_wf}, {16'h0, model_cnt});
      check("rnd_cnt_rf", {16'h0, cnt_rf}, {16'h0, model_cnt});
      $display("rnd %0d: we=%0b wreg=%0d wdata=%h r1=%0d r2=%0d dbg=%0d cnt=%0d",
               t, RegWrite_in, write_reg, write_data, read_reg1, read_reg2, dbg_reg, cnt_wf);
    end

    // Reset asserted between edges while a write to r9 is pending.
    drive(1'b1, 5'd9, 32'h55AA55AA, 5'd9, 5'd9, 5'd9);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd1_wf", rd1_wf, 32'h0);
    check("arst_rd2_rf", rd2_rf, 32'h0);
    check("arst_cnt", {16'h0, cnt_wf}, 32'h0);
    check("arst_dbg", dbg_wf, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      check($sformatf("arst_idx%0d_rd1", i), rd1_wf, 32'h0);
      check($sformatf("arst_idx%0d_rd2", i), rd2_wf, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    RegWrite_in = 1'b0;
    read_reg1 = 5'd9;
    model_reset();
    @(posedge clk);
    #1;
    check("arst_lost_write", rd1_wf, 32'h0);
    check("arst_cnt_after", {16'h0, cnt_wf}, 32'h0);
    $display("async reset: r9=%h cnt=%0d", rd1_wf, cnt_wf);

    // Counter wrap: 65535 writes to reach FFFF, then one more.
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd1, 5'd2, 5'd0);
      model_commit();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd0);
    #1;
    check("wrap_cnt_ffff", {16'h0, cnt_wf}, {16'h0, model_cnt});
    check("wrap_cnt_ffff_abs", {16'h0, cnt_rf}, 32'h0000FFFF);
    check("wrap_rd1", rd1_wf, model_regs[1]);
    drive(1'b1, 5'd4, 32'h0BADC0DE, 5'd4, 5'd4, 5'd0);
    model_commit();
    @(posedge clk);
    #1;
    check("wrap_cnt_zero", {16'h0, cnt_wf}, 32'h0);
    check("wrap_rd_r4", rd1_rf, 32'h0BADC0DE);
    $display("wrap: cnt=%0d r4=%h", cnt_wf, rd1_rf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
